input_channel: RTL and testbench

Ingress stage of the router port. It buffers incoming flits from the link in a FIFO and decodes the destination from each packet header. It then raises a one-hot request towards the crossbar and holds it until the packet's end-of-packet flit has been transferred. Its `x_req`, `x_rok` and `x_dout` outputs feed the `x_req`/`x_rok`/`x_din` slices of every output channel, and it consumes the grant and read strobe returned by them.

---
 rtl/input_channel_if.sv | 25 ++
 rtl/input_channel.sv | 114 +++++++++++
 tb/tb_input_channel.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/input_channel_if.sv
// rtl/input_channel_if.sv - link and crossbar handshake bundle of a router input channel
interface input_channel_if #(
    parameter int DATA_WIDTH      = 70,
    parameter int NUMBER_CHANNELS = 5
);
    logic [DATA_WIDTH-1:0]      in_data;
    logic                       in_val;
    logic                       in_ack;
    logic [NUMBER_CHANNELS-1:0] x_req;
    logic                       x_rok;
    logic [DATA_WIDTH-1:0]      x_dout;
    logic [NUMBER_CHANNELS-1:0] x_gnt;
    logic                       x_rd;
    logic                       err;

    modport master (
        output in_data, in_val, x_gnt, x_rd,
        input  in_ack, x_req, x_rok, x_dout, err
    );

    modport slave (
        input  in_data, in_val, x_gnt, x_rd,
        output in_ack, x_req, x_rok, x_dout, err
    );
endinterface

// File: rtl/input_channel.sv
// rtl/input_channel.sv - router ingress: flit FIFO, header decode, one-hot crossbar request
module input_channel #(
    parameter int DATA_WIDTH      = 70,
    parameter int NUMBER_CHANNELS = 5,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_WIDTH      = 2,
    parameter int DEST_WIDTH      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input_channel_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t                     state, state_nx;
    logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0]      rd_ptr, wr_ptr;
    logic [FIFO_WIDTH:0]        count;
    logic                       empty, full, wr_en;
    logic                       pop_xfer, pop_drop, pop;
    logic [NUMBER_CHANNELS-1:0] x_req, req_nx;
    logic                       err_q, err_nx;
    logic [DATA_WIDTH-1:0]      head;
    logic                       head_bop, head_eop, dest_ok;
    logic [DEST_WIDTH-1:0]      head_dest;

    assign empty     = (count == '0);
    assign full      = (count == (FIFO_WIDTH+1)'(FIFO_DEPTH));
    assign head      = mem[rd_ptr];
    assign head_bop  = head[DATA_WIDTH-1];
    assign head_eop  = head[DATA_WIDTH-2];
    assign head_dest = head[DEST_WIDTH-1:0];
    assign dest_ok   = (32'(head_dest) < NUMBER_CHANNELS);

    // Crossbar only sees the head while a packet owns this channel.
    assign bus.x_rok  = (state == ROUTE) && !empty;
    assign bus.x_req  = x_req;
    assign bus.x_dout = head;
    assign bus.err    = err_q;
    assign bus.in_ack = !full && !rst;

    assign wr_en    = bus.in_val && bus.in_ack;
    assign pop_xfer = bus.x_rd && bus.x_rok && (|(bus.x_gnt & x_req));
    assign pop      = pop_xfer || pop_drop;

    // Packet FSM: decode header in IDLE, forward in ROUTE, flush a misrouted packet in DROP.
    always_comb begin
        state_nx = state;
        req_nx   = x_req;
        pop_drop = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (!head_bop) begin
                        pop_drop = 1'b1;
                        err_nx   = 1'b1;
                    end else if (dest_ok) begin
                        req_nx   = NUMBER_CHANNELS'(1) << head_dest;
                        state_nx = ROUTE;
                    end else begin
                        pop_drop = 1'b1;
                        err_nx   = 1'b1;
                        if (!head_eop) state_nx = DROP;
                    end
                end
            end
            ROUTE: begin
                if (pop_xfer && head_eop) begin
                    req_nx   = '0;
                    state_nx = IDLE;
                end
            end
            DROP: begin
                if (!empty) begin
                    pop_drop = 1'b1;
                    if (head_eop) state_nx = IDLE;
                end
            end
            default: begin
                req_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // State, request, error pulse and FIFO bookkeeping; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            x_req  <= '0;
            err_q  <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_nx;
            x_req <= req_nx;
            err_q <= err_nx;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Flit storage; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= bus.in_data;
    end
endmodule

// File: tb/tb_input_channel.sv
// tb/tb_input_channel.sv - directed self-checking bench for input_channel
module tb_input_channel;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    input_channel_if #(.DATA_WIDTH(70), .NUMBER_CHANNELS(5)) bus ();

    input_channel #(
        .DATA_WIDTH(70), .NUMBER_CHANNELS(5), .FIFO_DEPTH(4), .FIFO_WIDTH(2), .DEST_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [69:0] flit(input logic bop, input logic eop, input logic [67:0] pl);
        return {bop, eop, pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [69:0] hdr;
        logic [69:0] tail;
        logic [4:0]  g;

        // reset with the link already offering a flit
        rst = 1'b1;
        bus.in_val = 1'b1;
        bus.in_data = flit(1'b1, 1'b0, 68'd2);
        bus.x_gnt = 5'b0;
        bus.x_rd = 1'b0;
        tick();
        chk("rst_in_ack", 70'(bus.in_ack), 70'(1'b0));
        chk("rst_x_req", 70'(bus.x_req), 70'(5'b0));
        chk("rst_x_rok", 70'(bus.x_rok), 70'(1'b0));
        chk("rst_err", 70'(bus.err), 70'(1'b0));
        chk("rst_count", 70'(dut.count), 70'(3'd0));
        rst = 1'b0;
        bus.in_val = 1'b0;
        tick();
        chk("rel_in_ack", 70'(bus.in_ack), 70'(1'b1));
        chk("rel_count", 70'(dut.count), 70'(3'd0));

        // 3-flit packet to channel 2, grant and read held
        bus.x_gnt = 5'b00100;
        bus.x_rd = 1'b1;
        bus.in_val = 1'b1;
        bus.in_data = flit(1'b1, 1'b0, 68'd2);
        tick();
        chk("p1_req_lat", 70'(bus.x_req), 70'(5'b0));
        chk("p1_head", bus.x_dout, flit(1'b1, 1'b0, 68'd2));
        bus.in_data = flit(1'b0, 1'b0, 68'h1234);
        tick();
        chk("p1_req", 70'(bus.x_req), 70'(5'b00100));
        chk("p1_rok", 70'(bus.x_rok), 70'(1'b1));
        chk("p1_dout_h", bus.x_dout, flit(1'b1, 1'b0, 68'd2));
        bus.in_data = flit(1'b0, 1'b1, 68'h5678);
        tick();
        chk("p1_dout_d", bus.x_dout, flit(1'b0, 1'b0, 68'h1234));
        chk("p1_req_hold", 70'(bus.x_req), 70'(5'b00100));
        chk("p1_err", 70'(bus.err), 70'(1'b0));
        bus.in_val = 1'b0;
        tick();
        chk("p1_dout_e", bus.x_dout, flit(1'b0, 1'b1, 68'h5678));
        chk("p1_rok_e", 70'(bus.x_rok), 70'(1'b1));
        tick();
        chk("p1_req_done", 70'(bus.x_req), 70'(5'b0));
        chk("p1_rok_done", 70'(bus.x_rok), 70'(1'b0));
        chk("p1_count", 70'(dut.count), 70'(3'd0));
        chk("p1_err_done", 70'(bus.err), 70'(1'b0));

        // fill the buffer with no grant
        bus.x_gnt = 5'b0;
        bus.x_rd = 1'b0;
        bus.in_val = 1'b1;
        bus.in_data = flit(1'b1, 1'b0, 68'd1);
        tick();
        bus.in_data = flit(1'b0, 1'b0, 68'hA1);
        tick();
        bus.in_data = flit(1'b0, 1'b0, 68'hA2);
        tick();
        bus.in_data = flit(1'b0, 1'b1, 68'hA3);
        tick();
        chk("full_count", 70'(dut.count), 70'(3'd4));
        chk("full_in_ack", 70'(bus.in_ack), 70'(1'b0));
        chk("full_req", 70'(bus.x_req), 70'(5'b00010));
        chk("full_rok", 70'(bus.x_rok), 70'(1'b1));
        bus.in_data = flit(1'b1, 1'b1, 68'd0);
        tick();
        chk("full_count2", 70'(dut.count), 70'(3'd4));
        chk("full_in_ack2", 70'(bus.in_ack), 70'(1'b0));
        chk("full_head", bus.x_dout, flit(1'b1, 1'b0, 68'd1));
        bus.x_gnt = 5'b00010;
        bus.x_rd = 1'b1;
        tick();
        chk("unfull_count", 70'(dut.count), 70'(3'd3));
        chk("unfull_in_ack", 70'(bus.in_ack), 70'(1'b1));
        chk("unfull_head", bus.x_dout, flit(1'b0, 1'b0, 68'hA1));
        bus.in_val = 1'b0;
        tick();
        tick();
        chk("drain_head", bus.x_dout, flit(1'b0, 1'b1, 68'hA3));
        chk("drain_count", 70'(dut.count), 70'(3'd1));
        tick();
        chk("drain_done_count", 70'(dut.count), 70'(3'd0));
        chk("drain_done_req", 70'(bus.x_req), 70'(5'b0));

        // ten 2-flit packets cycling all destinations; pointers wrap repeatedly
        for (int i = 0; i < 10; i++) begin
            g = 5'(1 << (i % 5));
            hdr = flit(1'b1, 1'b0, 68'((i << 8) | (i % 5)));
            tail = flit(1'b0, 1'b1, 68'(32'hE00 + i));
            bus.x_gnt = g;
            bus.x_rd = 1'b1;
            bus.in_val = 1'b1;
            bus.in_data = hdr;
            tick();
            bus.in_data = tail;
            tick();
            chk("wrap_req", 70'(bus.x_req), 70'(g));
            chk("wrap_hdr", bus.x_dout, hdr);
            bus.in_val = 1'b0;
            tick();
            chk("wrap_tail", bus.x_dout, tail);
            tick();
            chk("wrap_req_done", 70'(bus.x_req), 70'(5'b0));
            chk("wrap_count", 70'(dut.count), 70'(3'd0));
        end

        // bad destination 6 in a 3-flit packet, no grant needed to flush
        bus.x_gnt = 5'b0;
        bus.x_rd = 1'b0;
        bus.in_val = 1'b1;
        bus.in_data = flit(1'b1, 1'b0, 68'd6);
        tick();
        bus.in_data = flit(1'b0, 1'b0, 68'hB1);
        tick();
        chk("bad_err", 70'(bus.err), 70'(1'b1));
        chk("bad_req", 70'(bus.x_req), 70'(5'b0));
        chk("bad_rok", 70'(bus.x_rok), 70'(1'b0));
        chk("bad_count1", 70'(dut.count), 70'(3'd1));
        bus.in_data = flit(1'b0, 1'b1, 68'hB2);
        tick();
        chk("bad_err_once", 70'(bus.err), 70'(1'b0));
        chk("bad_count2", 70'(dut.count), 70'(3'd1));
        chk("bad_req2", 70'(bus.x_req), 70'(5'b0));
        bus.in_val = 1'b0;
        tick();
        chk("bad_count3", 70'(dut.count), 70'(3'd0));
        chk("bad_err3", 70'(bus.err), 70'(1'b0));
        chk("bad_req3", 70'(bus.x_req), 70'(5'b0));

        // next packet to channel 0 routes normally
        bus.x_gnt = 5'b00001;
        bus.x_rd = 1'b1;
        bus.in_val = 1'b1;
        bus.in_data = flit(1'b1, 1'b0, 68'd0);
        tick();
        bus.in_data = flit(1'b0, 1'b1, 68'hC1);
        tick();
        chk("d0_req", 70'(bus.x_req), 70'(5'b00001));
        bus.in_val = 1'b0;
        tick();
        chk("d0_tail", bus.x_dout, flit(1'b0, 1'b1, 68'hC1));
        tick();
        chk("d0_req_done", 70'(bus.x_req), 70'(5'b0));

        // stray body flit in IDLE; x_rd asserted while x_rok is low
        bus.x_gnt = 5'b0;
        bus.x_rd = 1'b1;
        bus.in_val = 1'b1;
        bus.in_data = flit(1'b0, 1'b0, 68'hD0);
        tick();
        bus.in_val = 1'b0;
        chk("stray_err0", 70'(bus.err), 70'(1'b0));
        chk("stray_count0", 70'(dut.count), 70'(3'd1));
        tick();
        chk("stray_err", 70'(bus.err), 70'(1'b1));
        chk("stray_count", 70'(dut.count), 70'(3'd0));
        tick();
        chk("stray_err_end", 70'(bus.err), 70'(1'b0));

        // single-flit packet to channel 4
        bus.x_gnt = 5'b10000;
        bus.in_val = 1'b1;
        bus.in_data = flit(1'b1, 1'b1, 68'd4);
        tick();
        bus.in_val = 1'b0;
        chk("single_req_lat", 70'(bus.x_req), 70'(5'b0));
        tick();
        chk("single_req", 70'(bus.x_req), 70'(5'b10000));
        chk("single_rok", 70'(bus.x_rok), 70'(1'b1));
        tick();
        chk("single_req_done", 70'(bus.x_req), 70'(5'b0));
        chk("single_count", 70'(dut.count), 70'(3'd0));
        tick();
        chk("single_req_idle", 70'(bus.x_req), 70'(5'b0));

        // grant from the wrong channel must not pop
        bus.x_gnt = 5'b00001;
        bus.in_val = 1'b1;
        bus.in_data = flit(1'b1, 1'b0, 68'd3);
        tick();
        bus.in_data = flit(1'b0, 1'b1, 68'hF1);
        tick();
        bus.in_val = 1'b0;
        chk("wg_req", 70'(bus.x_req), 70'(5'b01000));
        chk("wg_head", bus.x_dout, flit(1'b1, 1'b0, 68'd3));
        chk("wg_count", 70'(dut.count), 70'(3'd2));
        tick();
        chk("wg_req2", 70'(bus.x_req), 70'(5'b01000));
        chk("wg_head2", bus.x_dout, flit(1'b1, 1'b0, 68'd3));
        chk("wg_count2", 70'(dut.count), 70'(3'd2));

        // correct grant pops the header, then reset mid-packet
        bus.x_gnt = 5'b01000;
        tick();
        chk("mid_head", bus.x_dout, flit(1'b0, 1'b1, 68'hF1));
        chk("mid_count", 70'(dut.count), 70'(3'd1));
        rst = 1'b1;
        tick();
        chk("mrst_req", 70'(bus.x_req), 70'(5'b0));
        chk("mrst_rok", 70'(bus.x_rok), 70'(1'b0));
        chk("mrst_in_ack", 70'(bus.in_ack), 70'(1'b0));
        chk("mrst_count", 70'(dut.count), 70'(3'd0));
        rst = 1'b0;
        tick();
        chk("post_count", 70'(dut.count), 70'(3'd0));
        chk("post_in_ack", 70'(bus.in_ack), 70'(1'b1));
        chk("post_req", 70'(bus.x_req), 70'(5'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
